// File: rtl/trace_pkg.sv
// Shared types and constants for commit_trace_tx and its record FIFO.
// Defining TRACE_CYCLE_EN adds a cycle-stamp field and one extra word per record.
package trace_pkg;

  typedef enum logic [2:0] {
    KIND_NOP   = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_HALT  = 3'd4
  } kind_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_INUM = 3'd2;
  localparam logic [2:0] ST_PC   = 3'd3;
  localparam logic [2:0] ST_D0   = 3'd4;
  localparam logic [2:0] ST_D1   = 3'd5;
  localparam logic [2:0] ST_CYC  = 3'd6;

  localparam logic [2:0] WORDS_NOP   = 3'd3;
  localparam logic [2:0] WORDS_REG   = 3'd4;
  localparam logic [2:0] WORDS_LOAD  = 3'd5;
  localparam logic [2:0] WORDS_STORE = 3'd5;
  localparam logic [2:0] WORDS_HALT  = 3'd3;
`ifdef TRACE_CYCLE_EN
  localparam logic [2:0] EXTRA_WORDS = 3'd1;
`else
  localparam logic [2:0] EXTRA_WORDS = 3'd0;
`endif

  // d0/d1 already hold the kind-specific payload words in send order.
  typedef struct packed {
    kind_e       kind;
    logic [3:0]  wrReg;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] d0;
    logic [15:0] d1;
`ifdef TRACE_CYCLE_EN
    logic [15:0] cyc;
`endif
  } record_t;

  function automatic kind_e classify(input logic regWrite, input logic memRead,
                                     input logic memWrite, input logic haltIn);
    if (regWrite && memRead) classify = KIND_LOAD;
    else if (regWrite)       classify = KIND_REG;
    else if (haltIn)         classify = KIND_HALT;
    else if (memWrite)       classify = KIND_STORE;
    else                     classify = KIND_NOP;
  endfunction

  function automatic logic [2:0] recordWords(input kind_e k);
    case (k)
      KIND_REG:   recordWords = WORDS_REG + EXTRA_WORDS;
      KIND_LOAD:  recordWords = WORDS_LOAD + EXTRA_WORDS;
      KIND_STORE: recordWords = WORDS_STORE + EXTRA_WORDS;
      KIND_HALT:  recordWords = WORDS_HALT + EXTRA_WORDS;
      default:    recordWords = WORDS_NOP + EXTRA_WORDS;
    endcase
  endfunction

  function automatic logic [2:0] wordPos(input logic [2:0] st);
    case (st)
      ST_HDR:  wordPos = 3'd0;
      ST_INUM: wordPos = 3'd1;
      ST_PC:   wordPos = 3'd2;
      ST_CYC:  wordPos = 3'd3;
      ST_D0:   wordPos = 3'd3 + EXTRA_WORDS;
      ST_D1:   wordPos = 3'd4 + EXTRA_WORDS;
      default: wordPos = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for commit_trace_tx; push while full is only legal together with pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  record_t pushData,
  input  logic    pop,
  output record_t popData,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  record_t    mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popData = mem[rdPtr[AW-1:0]];

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Captures retired-instruction records and serializes them as 16-bit words.
// Optional macro TRACE_CYCLE_EN stamps each record with a free-running cycle count.
module commit_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic [3:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        done
);
  logic [2:0]  stateR, nextState;
  record_t     curR, nextCur, newRec, fifoHead;
  logic [15:0] inumR;
  logic        haltSeenR, accept, xfer, lastXfer, serFree;
  logic        fifoFull, fifoEmpty, pushS, popS, directLoad, dropS;
  logic [15:0] instUnused;
`ifdef TRACE_CYCLE_EN
  logic [15:0] cycR;
`endif

  assign instUnused = inst;

  function automatic logic [2:0] advance(input logic [2:0] st);
    case (st)
      ST_HDR:  advance = ST_INUM;
      ST_INUM: advance = ST_PC;
      ST_PC:   advance = (EXTRA_WORDS != 3'd0) ? ST_CYC : ST_D0;
      ST_CYC:  advance = ST_D0;
      ST_D0:   advance = ST_D1;
      default: advance = ST_IDLE;
    endcase
  endfunction

  function automatic logic [15:0] wordFor(input logic [2:0] st, input record_t r);
    case (st)
      ST_HDR:  wordFor = {r.kind, r.wrReg, 9'd0};
      ST_INUM: wordFor = r.inum;
      ST_PC:   wordFor = r.pc;
`ifdef TRACE_CYCLE_EN
      ST_CYC:  wordFor = r.cyc;
`endif
      ST_D0:   wordFor = r.d0;
      ST_D1:   wordFor = r.d1;
      default: wordFor = 16'd0;
    endcase
  endfunction

  function automatic logic lastFor(input logic [2:0] st, input kind_e k);
    lastFor = (st != ST_IDLE) && ((wordPos(st) + 3'd1) == recordWords(k));
  endfunction

  // Build the record for this cycle's commit inputs.
  always_comb begin
    newRec      = '0;
    newRec.kind = classify(reg_write, mem_read, mem_write, halt);
    newRec.inum = inumR;
    newRec.pc   = pc;
    case (newRec.kind)
      KIND_REG: begin
        newRec.wrReg = wr_reg;
        newRec.d0    = wr_data;
      end
      KIND_LOAD: begin
        newRec.wrReg = wr_reg;
        newRec.d0    = wr_data;
        newRec.d1    = mem_addr;
      end
      KIND_STORE: begin
        newRec.d0 = mem_addr;
        newRec.d1 = mem_data;
      end
      default: newRec.d0 = 16'd0;
    endcase
`ifdef TRACE_CYCLE_EN
    newRec.cyc = cycR;
`endif
  end

  // A record finishing this cycle frees the serializer, so a full FIFO can still pop-and-push.
  always_comb begin
    xfer       = tx_valid & tx_ready;
    lastXfer   = xfer & tx_last;
    serFree    = (stateR == ST_IDLE) | lastXfer;
    accept     = commit_valid & ~haltSeenR;
    popS       = serFree & ~fifoEmpty;
    directLoad = accept & serFree & fifoEmpty;
    pushS      = accept & ~directLoad & (~fifoFull | popS);
    dropS      = accept & ~directLoad & fifoFull & ~popS;
    if (popS) begin
      nextCur   = fifoHead;
      nextState = ST_HDR;
    end else if (directLoad) begin
      nextCur   = newRec;
      nextState = ST_HDR;
    end else if (serFree) begin
      nextCur   = curR;
      nextState = ST_IDLE;
    end else if (xfer) begin
      nextCur   = curR;
      nextState = advance(stateR);
    end else begin
      nextCur   = curR;
      nextState = stateR;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pushS),
    .pushData (newRec),
    .pop      (popS),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Serializer state, registered word outputs and status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR    <= ST_IDLE;
      curR      <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 16'd0;
      tx_last   <= 1'b0;
      inumR     <= 16'd0;
      haltSeenR <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
      done      <= 1'b0;
    end else begin
      stateR   <= nextState;
      curR     <= nextCur;
      tx_valid <= (nextState != ST_IDLE);
      tx_data  <= wordFor(nextState, nextCur);
      tx_last  <= lastFor(nextState, nextCur.kind);
      if (accept) inumR <= inumR + 16'd1;
      if (accept && (newRec.kind == KIND_HALT)) haltSeenR <= 1'b1;
      if (dropS) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (lastXfer && (curR.kind == KIND_HALT)) done <= 1'b1;
    end
  end

`ifdef TRACE_CYCLE_EN
  // Free-running cycle stamp.
  always_ff @(posedge clk) begin
    if (!rst_n) cycR <= 16'd0;
    else        cycR <= cycR + 16'd1;
  end
`endif

endmodule
